multi_ch_serializer: RTL and testbench



---
 rtl/multi_ch_serializer_pkg.sv | 20 ++
 rtl/multi_ch_serializer_if.sv | 28 ++
 rtl/multi_ch_serializer_rr_pick.sv | 32 +++
 rtl/multi_ch_serializer.sv | 145 ++++++++++++++
 tb/tb_multi_ch_serializer.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/multi_ch_serializer_pkg.sv
// Shared types and sizing helpers for the multi-channel serializer.
package ser_pkg;

  localparam int unsigned MAX_NUM_CH = 16;
  localparam int unsigned MAX_WIDTH  = 32;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    PAR,
    GAP
  } ser_state_t;

  // Header width: a single channel still sends one header bit.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_ch_serializer_if.sv
// Channel-word inputs and serial-frame outputs of the multi-channel serializer.
interface multi_ch_serializer_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 8
);
  import ser_pkg::*;

  localparam int unsigned CH_W = ch_width(NUM_CH);

  logic [NUM_CH*WIDTH-1:0] data_in;
  logic [NUM_CH-1:0]       ch_en;
  logic                    serial_out;
  logic                    start;
  logic                    busy;
  logic                    frame_done;
  logic [CH_W-1:0]         cur_ch;

  modport master (
    output data_in, ch_en,
    input  serial_out, start, busy, frame_done, cur_ch
  );

  modport slave (
    input  data_in, ch_en,
    output serial_out, start, busy, frame_done, cur_ch
  );

endinterface

// File: rtl/multi_ch_serializer_rr_pick.sv
// Combinational round-robin picker: first enabled channel after the pointer, wrapping.
module rr_pick #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
) (
  input  logic [NUM_CH-1:0] i_ch_en,
  input  logic [CH_W-1:0]   i_ptr,
  output logic [CH_W-1:0]   o_grant,
  output logic              o_any_en
);

  int unsigned w_ptr;
  int unsigned w_best;
  int unsigned w_dist;

  always_comb begin
    w_ptr    = 32'(i_ptr);
    w_best   = NUM_CH + 1;
    w_dist   = 0;
    o_grant  = '0;
    o_any_en = |i_ch_en;
    // Distance from the pointer; the pointer's own channel is the farthest candidate.
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_dist = (k > w_ptr) ? (k - w_ptr) : (k + NUM_CH - w_ptr);
      if (i_ch_en[k] && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_grant = CH_W'(k);
      end
    end
  end

endmodule

// File: rtl/multi_ch_serializer.sv
// Time-multiplexes NUM_CH words onto one pin as header+data frames, MSB first.
// Optional SER_PARITY_EN adds an even-parity bit over header and data.
module multi_ch_serializer
  import ser_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  multi_ch_serializer_if.slave bus
);

  localparam int unsigned CH_W    = ch_width(NUM_CH);
  localparam int unsigned CNT_MAX = (WIDTH > CH_W) ? WIDTH : CH_W;
  localparam int unsigned CNT_W   = ch_width(CNT_MAX);

  ser_state_t       r_state;
  logic [CH_W-1:0]  r_ptr;
  logic [CH_W-1:0]  r_hdr;
  logic [CH_W-1:0]  r_cur_ch;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_serial;
  logic             r_start;
  logic             r_busy;
  logic             r_frame_done;
`ifdef SER_PARITY_EN
  logic             r_par;
`endif

  logic [CH_W-1:0]  w_grant;
  logic             w_any_en;
  logic             w_pick;
  logic [WIDTH-1:0] w_word;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_pick (
    .i_ch_en  (bus.ch_en),
    .i_ptr    (r_ptr),
    .o_grant  (w_grant),
    .o_any_en (w_any_en)
  );

  always_comb begin
    w_word = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (w_grant == CH_W'(k)) begin
        w_word = bus.data_in[k*WIDTH +: WIDTH];
      end
    end
  end

  // ch_en only matters in the cycle a new frame is picked.
  assign w_pick = w_any_en && ((r_state == IDLE) || (r_state == GAP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_ptr        <= CH_W'(NUM_CH - 1);
      r_hdr        <= '0;
      r_cur_ch     <= '0;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_serial     <= 1'b0;
      r_start      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef SER_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else begin
      r_start      <= 1'b0;
      r_frame_done <= 1'b0;
      if (w_pick) begin
        r_state  <= HDR;
        r_ptr    <= w_grant;
        r_cur_ch <= w_grant;
        r_hdr    <= w_grant << 1;
        r_shift  <= w_word;
        r_cnt    <= CNT_W'(CH_W - 1);
        r_serial <= w_grant[CH_W-1];
        r_start  <= 1'b1;
        r_busy   <= 1'b1;
`ifdef SER_PARITY_EN
        r_par    <= (^w_grant) ^ (^w_word);
`endif
      end else begin
        unique case (r_state)
          HDR: begin
            if (r_cnt == '0) begin
              r_state  <= DATA;
              r_cnt    <= CNT_W'(WIDTH - 1);
              r_serial <= r_shift[WIDTH-1];
              r_shift  <= r_shift << 1;
            end else begin
              r_cnt    <= r_cnt - 1'b1;
              r_serial <= r_hdr[CH_W-1];
              r_hdr    <= r_hdr << 1;
            end
          end
          DATA: begin
            if (r_cnt == '0) begin
`ifdef SER_PARITY_EN
              r_state      <= PAR;
              r_serial     <= r_par;
`else
              r_state      <= GAP;
              r_serial     <= 1'b0;
              r_frame_done <= 1'b1;
`endif
            end else begin
              r_cnt    <= r_cnt - 1'b1;
              r_serial <= r_shift[WIDTH-1];
              r_shift  <= r_shift << 1;
            end
          end
`ifdef SER_PARITY_EN
          PAR: begin
            r_state      <= GAP;
            r_serial     <= 1'b0;
            r_frame_done <= 1'b1;
          end
`endif
          GAP: begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_serial <= 1'b0;
          end
          IDLE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.serial_out = r_serial;
  assign bus.start      = r_start;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;
  assign bus.cur_ch     = r_cur_ch;

endmodule

// File: tb/tb_multi_ch_serializer.sv
// Directed bench for multi_ch_serializer (NUM_CH=4, WIDTH=8); honours SER_PARITY_EN.
module tb_multi_ch_serializer;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned CH_W   = 2;

`ifdef SER_PARITY_EN
  localparam int FLEN = 12;
  localparam logic [15:0] EXP_T1 = 16'h0294;  // 00 10100101 0 0
  localparam logic [15:0] EXP_T5 = 16'h041C;  // 01 00000111 0 0
`else
  localparam int FLEN = 11;
  localparam logic [15:0] EXP_T1 = 16'h014A;  // 00 10100101 0
  localparam logic [15:0] EXP_T5 = 16'h020E;  // 01 00000111 0
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multi_ch_serializer_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) u_if ();

  multi_ch_serializer #(
    .NUM_CH (NUM_CH),
    .WIDTH  (WIDTH)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0]     bits;
  logic [15:0]     fd;
  logic [CH_W-1:0] ch;
  logic [1:0]      seq     [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
  logic [7:0]      dat_tab [4] = '{8'hA5, 8'h5A, 8'h3C, 8'hC3};
  bit              seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at the negedge where start is high; leaves on the first negedge after GAP.
  task capture_frame;
    ch   = u_if.cur_ch;
    bits = '0;
    fd   = '0;
    for (int i = 0; i < FLEN; i++) begin
      bits = {bits[14:0], u_if.serial_out};
      fd   = {fd[14:0], u_if.frame_done};
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    u_if.ch_en   = '0;
    u_if.data_in = {8'hC3, 8'h3C, 8'h5A, 8'hA5};
    repeat (2) @(negedge clk);
    check("rst_serial", 32'(u_if.serial_out), 32'd0);
    check("rst_start",  32'(u_if.start),      32'd0);
    check("rst_busy",   32'(u_if.busy),       32'd0);
    check("rst_done",   32'(u_if.frame_done), 32'd0);
    check("rst_cur_ch", 32'(u_if.cur_ch),     32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(u_if.busy), 32'd0);

    // Test 1: single channel 0, 0xA5, repeating frames.
    u_if.ch_en = 4'b0001;
    @(negedge clk);
    check("t1_start_lat", 32'(u_if.start), 32'd1);
    check("t1_busy",      32'(u_if.busy),  32'd1);
    capture_frame();
    check("t1_ch",    32'(ch),   32'd0);
    check("t1_bits",  32'(bits), 32'(EXP_T1));
    check("t1_done",  32'(fd),   32'd1);
    check("t1_b2b_start", 32'(u_if.start), 32'd1);
    capture_frame();
    check("t1_rep_bits", 32'(bits), 32'(EXP_T1));

    // Test 2: round robin over channels 0,1,3.
    u_if.ch_en = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      check("t2_start", 32'(u_if.start), 32'd1);
      capture_frame();
      check("t2_ch",   32'(ch),                32'(seq[i]));
      check("t2_hdr",  32'(bits[FLEN-1 -: 2]), 32'(seq[i]));
      check("t2_data", 32'(bits[FLEN-3 -: 8]), 32'(dat_tab[seq[i]]));
    end

    // Test 3: snapshot of ch2 taken at HDR entry.
    u_if.ch_en = 4'b0100;
    capture_frame();
    check("t3_no_abort_ch", 32'(ch), 32'd0);
    u_if.data_in[16 +: 8] = 8'hFF;
    capture_frame();
    check("t3_ch",       32'(ch),                32'd2);
    check("t3_old_data", 32'(bits[FLEN-3 -: 8]), 32'h3C);
    capture_frame();
    check("t3_new_data", 32'(bits[FLEN-3 -: 8]), 32'hFF);

    // Test 4: disable during DATA; frame completes then IDLE.
    repeat (4) @(negedge clk);
    u_if.ch_en = '0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (u_if.frame_done) seen = 1'b1;
    end
    check("t4_frame_done", 32'(seen),      32'd1);
    check("t4_gap_busy",   32'(u_if.busy), 32'd1);
    @(negedge clk);
    check("t4_idle_busy",   32'(u_if.busy),       32'd0);
    check("t4_idle_serial", 32'(u_if.serial_out), 32'd0);
    check("t4_idle_cur_ch", 32'(u_if.cur_ch),     32'd2);
    repeat (3) @(negedge clk);
    check("t4_stay_idle", 32'(u_if.busy), 32'd0);

    // Test 6: async reset mid-DATA, then fresh frame on ch2.
    u_if.ch_en = 4'b0010;
    @(negedge clk);
    check("t6_start", 32'(u_if.start),  32'd1);
    check("t6_ch",    32'(u_if.cur_ch), 32'd1);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_busy",   32'(u_if.busy),       32'd0);
    check("t6_async_cur_ch", 32'(u_if.cur_ch),     32'd0);
    check("t6_async_serial", 32'(u_if.serial_out), 32'd0);
    check("t6_async_start",  32'(u_if.start),      32'd0);
    @(negedge clk);
    u_if.ch_en = 4'b0100;
    rst_n      = 1'b1;
    @(negedge clk);
    check("t6_rel_start", 32'(u_if.start), 32'd1);
    capture_frame();
    check("t6_rel_ch",   32'(ch),                32'd2);
    check("t6_rel_hdr",  32'(bits[FLEN-1 -: 2]), 32'd2);
    check("t6_rel_data", 32'(bits[FLEN-3 -: 8]), 32'hFF);

    // Test 5: ch1 = 0x07 (full frame, with parity bit when compiled in).
    u_if.ch_en = 4'b0010;
    u_if.data_in[8 +: 8] = 8'h07;
    capture_frame();
    check("t5_prev_ch", 32'(ch), 32'd2);
    capture_frame();
    check("t5_ch",   32'(ch),   32'd1);
    check("t5_bits", 32'(bits), 32'(EXP_T5));
    check("t5_done", 32'(fd),   32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
